// File: rtl/uart_receive.sv
// rtl/uart_receive.sv - 8N1-style UART receiver with mid-bit sampling and stop-bit error strobe
module uart_receive #(
    parameter int data_bits    = 8,
    parameter int clks_per_bit = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 rx,
    output logic [data_bits-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_busy
);

    localparam int CW = $clog2(clks_per_bit);
    localparam logic [CW-1:0] FULL_M1  = CW'(clks_per_bit - 1);
    localparam logic [CW-1:0] HALF_M1  = CW'(clks_per_bit / 2 - 1);
    localparam logic [3:0]    LAST_BIT = 4'(data_bits - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  s1_q, s2_q;
    logic [CW-1:0]         baud_q, baud_d;
    logic [3:0]            bit_q, bit_d;
    logic [data_bits-1:0]  shift_q, shift_d;
    logic [data_bits-1:0]  data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  ferr_q, ferr_d;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            s1_q    <= rx;
            s2_q    <= s1_q;
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!s2_q) begin
                    state_d = S_START;
                    baud_d  = '0;
                end
            end
            S_START: begin
                // Half a bit in, a real start bit must still read low.
                if (baud_q == HALF_M1) begin
                    baud_d = '0;
                    if (s2_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        bit_d   = '0;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            S_DATA: begin
                if (baud_q == FULL_M1) begin
                    baud_d = '0;
                    for (int i = 0; i < data_bits; i++) begin
                        if (bit_q == 4'(i)) shift_d[i] = s2_q;
                    end
                    if (bit_q == LAST_BIT) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            S_STOP: begin
                if (baud_q == FULL_M1) begin
                    baud_d = '0;
                    if (s2_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            S_BREAK: begin
                // A held-low line yields one error, then waits for idle.
                if (s2_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = ferr_q;
    assign rx_busy      = (state_q != S_IDLE);

endmodule
